scm_tcdm_bridge: RTL and testbench
==================================

# scm_tcdm_bridge

Upstream front-end for the FPGA register-file SCM (`register_file_1r_1w_be`, 1-cycle read latency). Converts a single TCDM-style slave port (req/gnt request, r_valid/r_ready response) into the SCM's separate read and write port signals. It also keeps responses in order through a small response FIFO, so masters may stall the response channel. Instantiated once per SCM bank in the FPGA memory subsystem.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: SCM byte-address width; word index is `[ADDR_WIDTH-1:2]`.
- `DATA_WIDTH`, 32: data width; a multiple of 8.
- `NUM_BYTE`, `DATA_WIDTH/8`: byte-enable width.
- `BUS_ADDR_WIDTH`, 32: width of incoming bus address.
- `RESP_DEPTH`, 2: response FIFO depth; at least 2.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_i`  in  1  request valid.
- `gnt_o`  out  1  request accepted this cycle.
- `wen_i`  in  1  1 = read, 0 = write.
- `add_i`  in  BUS_ADDR_WIDTH  byte address, bank-relative.
- `wdata_i`  in  DATA_WIDTH  write data.
- `be_i`  in  NUM_BYTE  byte enables (writes only).
- `r_valid_o`  out  1  response valid.
- `r_ready_i`  in  1  response consumed.
- `r_rdata_o`  out  DATA_WIDTH  read data; 0 for writes and errors.
- `r_opc_o`  out  1  1 = error response.
- `rf_read_en_o`, `rf_read_addr_o` [ADDR_WIDTH], `rf_read_data_i` [DATA_WIDTH]: SCM read port.
- `rf_write_en_o`, `rf_write_addr_o` [ADDR_WIDTH], `rf_write_data_o` [DATA_WIDTH], `rf_write_be_o` [NUM_BYTE]: SCM write port.

## Operation
- Handshake: a request is accepted in cycle T when `req_i && gnt_o`.
- `gnt_o = req_i && (count + s1_valid - pop) < RESP_DEPTH`, where `pop = r_valid_o && r_ready_i`.
- `gnt_o` is combinational from `r_ready_i`; this path is intentional and gives full throughput.
- Accepted read: `rf_read_en_o=1`, `rf_read_addr_o=add_i[ADDR_WIDTH-1:0]` in cycle T.
- Accepted write: `rf_write_en_o=1`, with address, data and `be_i` driven straight through in cycle T.
- All `rf_*` enables are 0 when nothing is accepted. Address and data outputs hold their last value.
- Stage 1 register (s1): `s1_valid`, `s1_read`, `s1_err` are loaded on acceptance.
- Cycle T+1: if `s1_valid`, push {data = `s1_read && !s1_err ? rf_read_data_i : 0`, err = `s1_err`} into the FIFO.
- FIFO output: head drives `r_valid_o = (count != 0)`, `r_rdata_o`, `r_opc_o`. The head is popped on `r_valid_o && r_ready_i`.
- Push and pop in the same cycle are legal at any count, including full.
- Responses leave in acceptance order, for reads and writes alike.
- A write with `be_i = 0` is accepted, changes no bytes, and returns a normal response.
- A read in T+1 of an address written in T returns the new data. The SCM updates on the T edge.

## Timing
- Reset values: `gnt_o=0`, `r_valid_o=0`, `r_rdata_o=0`, `r_opc_o=0`, all `rf_*_en_o=0`, addresses/data/be = 0. Count, pointers and s1 are cleared.
- Latency: accept at T → `r_valid_o` at T+2 when the FIFO was empty (registered output).
- Throughput: with `r_ready_i` held high, one request per cycle is sustained.
- If `r_ready_i=0`, at most RESP_DEPTH requests are outstanding. `gnt_o` stays 0 until a pop.
- A reset asserted mid-operation discards all in-flight and queued responses. Writes already issued to the SCM stay committed.

## Configuration
- `SCM_TCDM_ADDR_CHECK_EN` defined: any nonzero `add_i[BUS_ADDR_WIDTH-1:ADDR_WIDTH]`, or nonzero `add_i[1:0]`, is an error request.
  - It is accepted normally, but the SCM enables stay 0.
  - Its response has `r_opc_o=1` and `r_rdata_o=0`.
- Undefined: upper and lower bits are ignored (aliasing). `s1_err` is tied 0 and `r_opc_o` is constant 0.

## Structure
- Package `scm_tcdm_pkg`:
  - `scm_resp_t` struct {logic err; logic [DATA_WIDTH-1:0] data}, parameterised via a localparam default of 32.
  - Constant `SCM_TCDM_READ = 1'b1`.
- Sub-module `scm_resp_fifo`: synchronous FIFO of `scm_resp_t` with DEPTH, push, pop, count, head. Flip-flop storage, with wrap-around pointers.

## Test plan
- Write 0xDEADBEEF to address 0x8 with be=0xF, then read 0x8. Required: two responses in order; the read returns 0xDEADBEEF at T+2 after its grant; `r_opc_o=0`.
- Write 0x000000AA with be=0x1 over existing 0x11223344. Required: a subsequent read returns 0x112233AA.
- Back-to-back reads of 0x0, 0x4, 0x8 with `r_ready_i=1`. Required: `gnt_o` high every cycle; data returns on consecutive cycles.
- Hold `r_ready_i=0` and issue 4 reads. Required: exactly RESP_DEPTH=2 grants; `gnt_o` reasserts in the cycle `r_ready_i` rises; no response is lost or reordered.
- With `SCM_TCDM_ADDR_CHECK_EN`, write to 0x100 (ADDR_WIDTH=5). Required: `rf_write_en_o` stays 0; `r_opc_o=1`; the SCM contents are unchanged.
- Assert `rst_n=0` with 2 responses queued. Required: `r_valid_o=0` immediately; after release the first new read returns correct data.

Source files
------------

// File: rtl/scm_tcdm_pkg.sv
// Shared types and constants for the TCDM-to-SCM bridge.
// Optional feature macro used by the bridge: SCM_TCDM_ADDR_CHECK_EN.
package scm_tcdm_pkg;

  localparam int SCM_DATA_WIDTH = 32;

  localparam logic SCM_TCDM_READ = 1'b1;

  typedef struct packed {
    logic                      err;
    logic [SCM_DATA_WIDTH-1:0] data;
  } scm_resp_t;

endpackage

// File: rtl/scm_resp_fifo.sv
// Flip-flop response FIFO with wrap-around pointers; head is visible combinationally.
module scm_resp_fifo
  import scm_tcdm_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = scm_resp_t,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  T              data_i,
  output T              head_o,
  output logic [CW-1:0] count_o
);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  // A push into a full FIFO is only honoured when the head leaves in the same cycle.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = push_i && (!w_full || pop_i);
  assign w_pop   = pop_i && (r_count != '0);
  assign head_o  = r_mem[r_rptr];
  assign count_o = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/scm_tcdm_bridge.sv
// TCDM slave port to 1R/1W SCM adapter with an in-order response FIFO.
// Define SCM_TCDM_ADDR_CHECK_EN to turn out-of-range/misaligned addresses into error responses.
module scm_tcdm_bridge
  import scm_tcdm_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_BYTE       = DATA_WIDTH / 8,
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int RESP_DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic                      wen_i,
  input  logic [BUS_ADDR_WIDTH-1:0] add_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [NUM_BYTE-1:0]       be_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [DATA_WIDTH-1:0]     r_rdata_o,
  output logic                      r_opc_o,
  output logic                      rf_read_en_o,
  output logic [ADDR_WIDTH-1:0]     rf_read_addr_o,
  input  logic [DATA_WIDTH-1:0]     rf_read_data_i,
  output logic                      rf_write_en_o,
  output logic [ADDR_WIDTH-1:0]     rf_write_addr_o,
  output logic [DATA_WIDTH-1:0]     rf_write_data_o,
  output logic [NUM_BYTE-1:0]       rf_write_be_o
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  logic                  r_s1_valid;
  logic                  r_s1_read;
  logic                  r_s1_err;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [NUM_BYTE-1:0]   r_wr_be;

  logic [CW-1:0]         w_count;
  logic [CW:0]           w_level;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_addr_err;
  logic                  w_rd_fire;
  logic                  w_wr_fire;
  resp_t                 w_push_data;
  resp_t                 w_head;

`ifdef SCM_TCDM_ADDR_CHECK_EN
  assign w_addr_err = (|add_i[BUS_ADDR_WIDTH-1:ADDR_WIDTH]) || (|add_i[1:0]);
  assign r_opc_o    = w_head.err;
`else
  logic w_unused_bits;
  assign w_addr_err    = 1'b0;
  assign r_opc_o       = 1'b0;
  assign w_unused_bits = ^{add_i[BUS_ADDR_WIDTH-1:ADDR_WIDTH], w_head.err};
`endif

  // Occupancy the FIFO will have after this edge, counting the response still in s1.
  assign w_pop     = r_valid_o && r_ready_i;
  assign w_level   = {1'b0, w_count} + {{CW{1'b0}}, r_s1_valid} - {{CW{1'b0}}, w_pop};
  assign gnt_o     = req_i && (w_level < (CW + 1)'(RESP_DEPTH));
  assign w_accept  = req_i && gnt_o;
  assign w_rd_fire = w_accept && (wen_i == SCM_TCDM_READ) && !w_addr_err;
  assign w_wr_fire = w_accept && (wen_i != SCM_TCDM_READ) && !w_addr_err;

  assign rf_read_en_o    = w_rd_fire;
  assign rf_read_addr_o  = w_rd_fire ? add_i[ADDR_WIDTH-1:0] : r_rd_addr;
  assign rf_write_en_o   = w_wr_fire;
  assign rf_write_addr_o = w_wr_fire ? add_i[ADDR_WIDTH-1:0] : r_wr_addr;
  assign rf_write_data_o = w_wr_fire ? wdata_i : r_wr_data;
  assign rf_write_be_o   = w_wr_fire ? be_i : r_wr_be;

  // Stage 1 tracks the accepted request while the SCM produces read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_read  <= 1'b0;
      r_s1_err   <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_be    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_read  <= (wen_i == SCM_TCDM_READ);
      r_s1_err   <= w_addr_err;
      if (w_rd_fire) begin
        r_rd_addr <= add_i[ADDR_WIDTH-1:0];
      end
      if (w_wr_fire) begin
        r_wr_addr <= add_i[ADDR_WIDTH-1:0];
        r_wr_data <= wdata_i;
        r_wr_be   <= be_i;
      end
    end
  end

  always_comb begin
    w_push_data.err  = r_s1_err;
    w_push_data.data = '0;
    if (r_s1_read && !r_s1_err) begin
      w_push_data.data = rf_read_data_i;
    end else begin
      w_push_data.data = '0;
    end
  end

  scm_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .T     (resp_t)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (r_s1_valid),
    .pop_i   (w_pop),
    .data_i  (w_push_data),
    .head_o  (w_head),
    .count_o (w_count)
  );

  assign r_valid_o = (w_count != '0);
  assign r_rdata_o = w_head.data;

endmodule

// File: tb/tb_scm_tcdm_bridge.sv
// Directed bench for scm_tcdm_bridge with a behavioural 1-cycle-latency SCM attached.
module tb_scm_tcdm_bridge;

  logic        clk;
  logic        rst_n;
  logic        req_i;
  logic        gnt_o;
  logic        wen_i;
  logic [31:0] add_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        r_valid_o;
  logic        r_ready_i;
  logic [31:0] r_rdata_o;
  logic        r_opc_o;
  logic        rf_read_en_o;
  logic [4:0]  rf_read_addr_o;
  logic [31:0] rf_read_data_i;
  logic        rf_write_en_o;
  logic [4:0]  rf_write_addr_o;
  logic [31:0] rf_write_data_o;
  logic [3:0]  rf_write_be_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] scm_mem [8];

  scm_tcdm_bridge dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req_i),
    .gnt_o           (gnt_o),
    .wen_i           (wen_i),
    .add_i           (add_i),
    .wdata_i         (wdata_i),
    .be_i            (be_i),
    .r_valid_o       (r_valid_o),
    .r_ready_i       (r_ready_i),
    .r_rdata_o       (r_rdata_o),
    .r_opc_o         (r_opc_o),
    .rf_read_en_o    (rf_read_en_o),
    .rf_read_addr_o  (rf_read_addr_o),
    .rf_read_data_i  (rf_read_data_i),
    .rf_write_en_o   (rf_write_en_o),
    .rf_write_addr_o (rf_write_addr_o),
    .rf_write_data_o (rf_write_data_o),
    .rf_write_be_o   (rf_write_be_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SCM: byte-enabled write and registered read, both on the rising edge.
  always @(posedge clk) begin
    if (rf_write_en_o) begin
      for (int b = 0; b < 4; b++) begin
        if (rf_write_be_o[b]) scm_mem[rf_write_addr_o[4:2]][b*8 +: 8] <= rf_write_data_o[b*8 +: 8];
      end
    end
    if (rf_read_en_o) rf_read_data_i <= scm_mem[rf_read_addr_o[4:2]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then settle before sampling.
  task automatic drv(input logic req, input logic wen, input logic [31:0] add,
                     input logic [31:0] wd, input logic [3:0] be, input logic rdy);
    @(negedge clk);
    req_i     = req;
    wen_i     = wen;
    add_i     = add;
    wdata_i   = wd;
    be_i      = be;
    r_ready_i = rdy;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_i = 1'b0; wen_i = 1'b0; add_i = 32'h0;
    wdata_i = 32'h0; be_i = 4'h0; r_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", gnt_o, 1'b0);
    chk("rst_rvalid", r_valid_o, 1'b0);
    chk("rst_rdata", r_rdata_o, 32'h0);
    chk("rst_opc", r_opc_o, 1'b0);
    chk("rst_rd_en", rf_read_en_o, 1'b0);
    chk("rst_wr_en", rf_write_en_o, 1'b0);
    chk("rst_rd_addr", rf_read_addr_o, 5'h0);
    chk("rst_wr_addr", rf_write_addr_o, 5'h0);
    chk("rst_wr_data", rf_write_data_o, 32'h0);
    chk("rst_wr_be", rf_write_be_o, 4'h0);
    rst_n = 1'b1;

    // Write then read 0x8: responses in order, read data at T+2.
    drv(1'b1, 1'b0, 32'h8, 32'hDEADBEEF, 4'hF, 1'b1);
    chk("t1_w_gnt", gnt_o, 1'b1);
    chk("t1_w_en", rf_write_en_o, 1'b1);
    chk("t1_w_addr", rf_write_addr_o, 5'h8);
    chk("t1_w_data", rf_write_data_o, 32'hDEADBEEF);
    chk("t1_w_be", rf_write_be_o, 4'hF);
    chk("t1_w_rd_en", rf_read_en_o, 1'b0);
    drv(1'b1, 1'b1, 32'h8, 32'h0, 4'h0, 1'b1);
    chk("t1_r_gnt", gnt_o, 1'b1);
    chk("t1_r_en", rf_read_en_o, 1'b1);
    chk("t1_r_addr", rf_read_addr_o, 5'h8);
    chk("t1_r_wr_en", rf_write_en_o, 1'b0);
    chk("t1_lat_t1", r_valid_o, 1'b0);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t1_wresp_v", r_valid_o, 1'b1);
    chk("t1_wresp_d", r_rdata_o, 32'h0);
    chk("t1_wresp_opc", r_opc_o, 1'b0);
    chk("t1_idle_gnt", gnt_o, 1'b0);
    chk("t1_wr_addr_hold", rf_write_addr_o, 5'h8);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t1_rresp_v", r_valid_o, 1'b1);
    chk("t1_rresp_d", r_rdata_o, 32'hDEADBEEF);
    chk("t1_rresp_opc", r_opc_o, 1'b0);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t1_empty", r_valid_o, 1'b0);

    // Partial byte write and a be=0 write over 0x11223344 at 0xC.
    drv(1'b1, 1'b0, 32'hC, 32'h11223344, 4'hF, 1'b1);
    chk("t2_w1_gnt", gnt_o, 1'b1);
    drv(1'b1, 1'b0, 32'hC, 32'h000000AA, 4'h1, 1'b1);
    chk("t2_w2_gnt", gnt_o, 1'b1);
    drv(1'b1, 1'b0, 32'hC, 32'hFFFFFFFF, 4'h0, 1'b1);
    chk("t2_w3_gnt", gnt_o, 1'b1);
    chk("t2_w3_be", rf_write_be_o, 4'h0);
    chk("t2_w1_resp", r_valid_o, 1'b1);
    drv(1'b1, 1'b1, 32'hC, 32'h0, 4'h0, 1'b1);
    chk("t2_r_gnt", gnt_o, 1'b1);
    chk("t2_w2_resp", r_valid_o, 1'b1);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t2_w3_resp_v", r_valid_o, 1'b1);
    chk("t2_w3_resp_d", r_rdata_o, 32'h0);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t2_r_resp_v", r_valid_o, 1'b1);
    chk("t2_r_resp_d", r_rdata_o, 32'h112233AA);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t2_empty", r_valid_o, 1'b0);

    // Back-to-back reads at full throughput.
    drv(1'b1, 1'b0, 32'h0, 32'hA0A0A0A0, 4'hF, 1'b1);
    chk("t3_w0_gnt", gnt_o, 1'b1);
    drv(1'b1, 1'b0, 32'h4, 32'h0B0B0B0B, 4'hF, 1'b1);
    chk("t3_w4_gnt", gnt_o, 1'b1);
    drv(1'b1, 1'b1, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t3_r0_gnt", gnt_o, 1'b1);
    drv(1'b1, 1'b1, 32'h4, 32'h0, 4'h0, 1'b1);
    chk("t3_r4_gnt", gnt_o, 1'b1);
    drv(1'b1, 1'b1, 32'h8, 32'h0, 4'h0, 1'b1);
    chk("t3_r8_gnt", gnt_o, 1'b1);
    chk("t3_r0_data", r_rdata_o, 32'hA0A0A0A0);
    chk("t3_r0_valid", r_valid_o, 1'b1);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t3_r4_data", r_rdata_o, 32'h0B0B0B0B);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t3_r8_data", r_rdata_o, 32'hDEADBEEF);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t3_empty", r_valid_o, 1'b0);

    // Response back-pressure: only RESP_DEPTH grants until r_ready_i rises.
    drv(1'b1, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
    chk("t4_gnt_a0", gnt_o, 1'b1);
    drv(1'b1, 1'b1, 32'h4, 32'h0, 4'h0, 1'b0);
    chk("t4_gnt_a1", gnt_o, 1'b1);
    drv(1'b1, 1'b1, 32'h8, 32'h0, 4'h0, 1'b0);
    chk("t4_gnt_a2", gnt_o, 1'b0);
    chk("t4_rd_en_a2", rf_read_en_o, 1'b0);
    drv(1'b1, 1'b1, 32'h8, 32'h0, 4'h0, 1'b0);
    chk("t4_gnt_a3", gnt_o, 1'b0);
    chk("t4_valid_a3", r_valid_o, 1'b1);
    chk("t4_head_a3", r_rdata_o, 32'hA0A0A0A0);
    drv(1'b1, 1'b1, 32'h8, 32'h0, 4'h0, 1'b1);
    chk("t4_gnt_ready", gnt_o, 1'b1);
    chk("t4_data0", r_rdata_o, 32'hA0A0A0A0);
    drv(1'b1, 1'b1, 32'hC, 32'h0, 4'h0, 1'b1);
    chk("t4_gnt_a5", gnt_o, 1'b1);
    chk("t4_data4", r_rdata_o, 32'h0B0B0B0B);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t4_data8", r_rdata_o, 32'hDEADBEEF);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t4_dataC", r_rdata_o, 32'h112233AA);
    chk("t4_validC", r_valid_o, 1'b1);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t4_empty", r_valid_o, 1'b0);

    // Out-of-range write to 0x100: error response or alias to word 0.
    drv(1'b1, 1'b0, 32'h100, 32'h55555555, 4'hF, 1'b1);
    chk("t5_w_gnt", gnt_o, 1'b1);
`ifdef SCM_TCDM_ADDR_CHECK_EN
    chk("t5_w_en", rf_write_en_o, 1'b0);
`else
    chk("t5_w_en", rf_write_en_o, 1'b1);
    chk("t5_w_addr", rf_write_addr_o, 5'h0);
`endif
    drv(1'b1, 1'b1, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t5_r_gnt", gnt_o, 1'b1);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t5_wresp_v", r_valid_o, 1'b1);
    chk("t5_wresp_d", r_rdata_o, 32'h0);
`ifdef SCM_TCDM_ADDR_CHECK_EN
    chk("t5_wresp_opc", r_opc_o, 1'b1);
`else
    chk("t5_wresp_opc", r_opc_o, 1'b0);
`endif
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t5_rresp_opc", r_opc_o, 1'b0);
`ifdef SCM_TCDM_ADDR_CHECK_EN
    chk("t5_rresp_d", r_rdata_o, 32'hA0A0A0A0);
    drv(1'b1, 1'b1, 32'h2, 32'h0, 4'h0, 1'b1);
    chk("t5_mis_rd_en", rf_read_en_o, 1'b0);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t5_mis_opc", r_opc_o, 1'b1);
    chk("t5_mis_d", r_rdata_o, 32'h0);
`else
    chk("t5_rresp_d", r_rdata_o, 32'h55555555);
`endif
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t5_empty", r_valid_o, 1'b0);

    // Reset with two queued responses, then a fresh read.
    drv(1'b1, 1'b1, 32'h8, 32'h0, 4'h0, 1'b0);
    chk("t6_gnt0", gnt_o, 1'b1);
    drv(1'b1, 1'b1, 32'hC, 32'h0, 4'h0, 1'b0);
    chk("t6_gnt1", gnt_o, 1'b1);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    chk("t6_queued", r_valid_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", r_valid_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drv(1'b1, 1'b1, 32'h8, 32'h0, 4'h0, 1'b1);
    chk("t6_post_gnt", gnt_o, 1'b1);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t6_post_lat", r_valid_o, 1'b0);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t6_post_v", r_valid_o, 1'b1);
    chk("t6_post_d", r_rdata_o, 32'hDEADBEEF);
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    chk("t6_empty", r_valid_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
